// File: rtl/reaction_ctrl_if.sv
// Button, LFSR and display-side signals of the reaction-timer sequencer.
// Pure wiring; no latency of its own.
// No backpressure: buttons are levels, results are pulses/held values.
interface reaction_ctrl_if #(
  parameter int N = 12
);
  logic         start;
  logic         react;
  logic [N-1:0] random;
  logic         led;
  logic         busy;
  logic [13:0]  rt_ms;
  logic         rt_valid;
  logic [13:0]  best_ms;
  logic         false_start;
  logic         timeout;

  // Drives buttons and LFSR value, observes the game outputs.
  modport master (
    output start, react, random,
    input  led, busy, rt_ms, rt_valid, best_ms, false_start, timeout
  );

  // The sequencer itself.
  modport slave (
    input  start, react, random,
    output led, busy, rt_ms, rt_valid, best_ms, false_start, timeout
  );
endinterface

// File: rtl/reaction_ctrl.sv
// Reaction-timer sequencer: random foreperiod, stimulus LED, reaction measurement, best time.
// Button edge to state change is one cycle; all outputs come straight from registers/state.
// No backpressure: button edges are acted on the cycle they are seen or ignored by state.
module reaction_ctrl #(
  parameter int N         = 12,
  parameter int TICK_DIV  = 50000,
  parameter int MIN_DELAY = 1000,
  parameter int MAX_RT    = 9999
) (
  input  logic          clk,
  input  logic          reset,
  reaction_ctrl_if.slave bus
);

  // Tick prescaler must reach TICK_DIV-1, which can exceed the 14-bit game counters.
  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [13:0]   MIN_D     = 14'(MIN_DELAY);
  localparam logic [13:0]   RT_MAX    = 14'(MAX_RT);
  localparam logic [13:0]   RT_LAST   = 14'(MAX_RT - 1);
  localparam logic [13:0]   BEST_INIT = 14'h3FFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_GO,
    S_DONE,
    S_FAULT,
    S_TOUT
  } state_t;

  state_t          state_q, state_d;
  logic            start_q, react_q;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [13:0]     delay_cnt_q, delay_cnt_d;
  logic [13:0]     rt_cnt_q, rt_cnt_d;
  logic [13:0]     rt_ms_q, rt_ms_d;
  logic            rt_valid_q, rt_valid_d;
  logic [13:0]     best_ms_q, best_ms_d;

  logic start_e, react_e, tick;

  // Button levels reset high so a button held through reset never looks like a press.
  assign start_e = bus.start & ~start_q;
  assign react_e = bus.react & ~react_q;
  assign tick    = (tick_cnt_q == TICK_LAST);

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b1;
      react_q     <= 1'b1;
      tick_cnt_q  <= '0;
      delay_cnt_q <= '0;
      rt_cnt_q    <= '0;
      rt_ms_q     <= '0;
      rt_valid_q  <= 1'b0;
      best_ms_q   <= BEST_INIT;
    end else begin
      state_q     <= state_d;
      start_q     <= bus.start;
      react_q     <= bus.react;
      tick_cnt_q  <= tick_cnt_d;
      delay_cnt_q <= delay_cnt_d;
      rt_cnt_q    <= rt_cnt_d;
      rt_ms_q     <= rt_ms_d;
      rt_valid_q  <= rt_valid_d;
      best_ms_q   <= best_ms_d;
    end
  end

  // Next-state: foreperiod countdown, reaction count, result capture; react beats expiring ticks.
  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    delay_cnt_d = delay_cnt_q;
    rt_cnt_d    = rt_cnt_q;
    rt_ms_d     = rt_ms_q;
    rt_valid_d  = 1'b0;
    best_ms_d   = best_ms_q;

    case (state_q)
      S_WAIT: begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
        if (tick) begin
          delay_cnt_d = delay_cnt_q - 14'd1;
        end
        if (react_e) begin
          state_d = S_FAULT;
        end else if (tick && delay_cnt_q == 14'd1) begin
          state_d    = S_GO;
          tick_cnt_d = '0;
          rt_cnt_d   = '0;
        end
      end

      S_GO: begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
        if (tick) begin
          rt_cnt_d = rt_cnt_q + 14'd1;
        end
        if (react_e) begin
          // Report completed milliseconds, ignoring any tick landing in this cycle.
          state_d    = S_DONE;
          rt_ms_d    = rt_cnt_q;
          rt_valid_d = 1'b1;
          if (rt_cnt_q < best_ms_q) begin
            best_ms_d = rt_cnt_q;
          end
        end else if (tick && rt_cnt_q == RT_LAST) begin
          state_d = S_TOUT;
          rt_ms_d = RT_MAX;
        end
      end

      default: begin
        // IDLE, DONE, FAULT, TOUT: only a start press does anything.
        if (start_e) begin
          state_d     = S_WAIT;
          delay_cnt_d = MIN_D + 14'(bus.random);
          tick_cnt_d  = '0;
        end
      end
    endcase
  end

  assign bus.led         = (state_q == S_GO);
  assign bus.busy        = (state_q == S_WAIT) || (state_q == S_GO);
  assign bus.false_start = (state_q == S_FAULT);
  assign bus.timeout     = (state_q == S_TOUT);
  assign bus.rt_ms       = rt_ms_q;
  assign bus.rt_valid    = rt_valid_q;
  assign bus.best_ms     = best_ms_q;

endmodule

// File: tb/tb_reaction_ctrl.sv
// Bench for reaction_ctrl: directed game scenarios plus random button traffic.
// Outputs are compared every cycle against a timestamp-based reference model.
// No backpressure in the design; inputs are driven on the falling edge.
module tb_reaction_ctrl;
  localparam int N     = 4;
  localparam int TD    = 4;
  localparam int MIND  = 2;
  localparam int MAXRT = 12;

  localparam int P_IDLE  = 0;
  localparam int P_WAIT  = 1;
  localparam int P_GO    = 2;
  localparam int P_DONE  = 3;
  localparam int P_FAULT = 4;
  localparam int P_TOUT  = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  reaction_ctrl_if #(.N(N)) bus ();

  reaction_ctrl #(
    .N(N), .TICK_DIV(TD), .MIN_DELAY(MIND), .MAX_RT(MAXRT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_on = 1'b0;

  // Reference model: phase plus the absolute cycle numbers at which WAIT and GO began.
  int m_ph    = P_IDLE;
  int m_rt    = 0;
  int m_best  = 16383;
  int m_valid = 0;
  int t_wait  = 0;
  int t_go    = 0;
  int d_ms    = 0;
  int cyc     = 0;
  bit p_start = 1'b1;
  bit p_react = 1'b1;
  bit se, re;
  int elapsed;

  always @(posedge clk) begin
    if (!reset) begin
      m_ph = P_IDLE; m_rt = 0; m_best = 16383; m_valid = 0;
      p_start = 1'b1; p_react = 1'b1;
    end else begin
      se = bus.start && !p_start;
      re = bus.react && !p_react;
      m_valid = 0;
      if (m_ph == P_WAIT) begin
        if (re) m_ph = P_FAULT;
        else if (cyc + 1 == t_wait + d_ms * TD) begin
          m_ph = P_GO;
          t_go = cyc + 1;
        end
      end else if (m_ph == P_GO) begin
        elapsed = cyc - t_go;
        if (re) begin
          m_ph    = P_DONE;
          m_rt    = elapsed / TD;
          m_valid = 1;
          if (m_rt < m_best) m_best = m_rt;
        end else if (cyc + 1 == t_go + MAXRT * TD) begin
          m_ph = P_TOUT;
          m_rt = MAXRT;
        end
      end else if (se) begin
        m_ph   = P_WAIT;
        t_wait = cyc + 1;
        d_ms   = MIND + int'(bus.random);
      end
      p_start = bus.start;
      p_react = bus.react;
    end
    cyc++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [31:0] exp_flags();
    return {27'd0, m_ph == P_GO, (m_ph == P_WAIT) || (m_ph == P_GO), m_valid == 1,
            m_ph == P_FAULT, m_ph == P_TOUT};
  endfunction

  // One clock: wait for the falling edge, then compare every output with the model.
  task automatic step();
    @(negedge clk);
    if (chk_on) begin
      check_eq("flags", {27'd0, bus.led, bus.busy, bus.rt_valid, bus.false_start, bus.timeout},
               exp_flags());
      check_eq("rt_ms", 32'(bus.rt_ms), m_rt);
      check_eq("best_ms", 32'(bus.best_ms), m_best);
    end
  endtask

  task automatic wait_led(output int cnt);
    cnt = 0;
    while (bus.led !== 1'b1 && cnt < 500) begin
      step();
      cnt++;
    end
  endtask

  task automatic wait_tout(output int cnt);
    cnt = 0;
    while (bus.timeout !== 1'b1 && cnt < 500) begin
      step();
      cnt++;
    end
  endtask

  task automatic play(input int rnd, input int rt);
    int c;
    bus.random = N'(rnd); bus.start = 1'b1; step(); bus.start = 1'b0;
    wait_led(c);
    repeat (rt * TD + $urandom_range(0, TD - 1)) step();
    bus.react = 1'b1; step(); bus.react = 1'b0;
    check_eq("play_rt_valid", 32'(bus.rt_valid), 1);
    check_eq("play_rt_ms", 32'(bus.rt_ms), rt);
  endtask

  initial begin
    int cnt, cnt2;
    bus.start = 1'b0; bus.react = 1'b0; bus.random = '0;
    step(); step();
    chk_on = 1'b1;

    // Start held across reset release must not begin a game.
    bus.start = 1'b1; step();
    reset = 1'b1; repeat (4) step();
    check_eq("held_start_idle", 32'(bus.busy), 0);
    bus.start = 1'b0; step();
    check_eq("reset_rt_ms", 32'(bus.rt_ms), 0);
    check_eq("reset_best", 32'(bus.best_ms), 16383);

    // Normal game.
    bus.random = 4'd5; bus.start = 1'b1; step();
    check_eq("start_busy", 32'(bus.busy), 1);
    bus.start = 1'b0;
    wait_led(cnt);
    check_eq("led_onset", cnt, 28);
    repeat (12) step();
    bus.react = 1'b1; step();
    check_eq("normal_valid", 32'(bus.rt_valid), 1);
    check_eq("normal_rt_ms", 32'(bus.rt_ms), 3);
    check_eq("normal_best", 32'(bus.best_ms), 3);
    check_eq("normal_led_off", 32'(bus.led), 0);
    bus.react = 1'b0; step();
    check_eq("valid_one_cycle", 32'(bus.rt_valid), 0);

    // False start.
    bus.start = 1'b1; step(); bus.start = 1'b0;
    repeat (9) step();
    bus.react = 1'b1; step(); bus.react = 1'b0;
    check_eq("fs_set", 32'(bus.false_start), 1);
    repeat (40) step();
    check_eq("fs_no_led", 32'(bus.led), 0);
    check_eq("fs_rt_kept", 32'(bus.rt_ms), 3);
    check_eq("fs_best_kept", 32'(bus.best_ms), 3);
    bus.start = 1'b1; step(); bus.start = 1'b0;
    check_eq("fs_cleared", 32'(bus.false_start), 0);

    // Start presses in WAIT and GO are ignored; then timeout.
    repeat (3) step();
    bus.start = 1'b1; step(); bus.start = 1'b0;
    wait_led(cnt);
    check_eq("wait_start_ignored", cnt, 24);
    repeat (5) step();
    bus.start = 1'b1; step(); bus.start = 1'b0;
    wait_tout(cnt2);
    check_eq("tout_delay", cnt2 + 6, MAXRT * TD);
    check_eq("tout_rt_ms", 32'(bus.rt_ms), MAXRT);
    check_eq("tout_best", 32'(bus.best_ms), 3);

    // Best tracking from a fresh reset.
    reset = 1'b0; step(); reset = 1'b1; step();
    play(1, 7); check_eq("best_a", 32'(bus.best_ms), 7);
    play(6, 3); check_eq("best_b", 32'(bus.best_ms), 3);
    play(0, 9); check_eq("best_c", 32'(bus.best_ms), 3);

    // React on the final WAIT tick wins.
    bus.random = 4'd3; bus.start = 1'b1; step(); bus.start = 1'b0;
    repeat ((MIND + 3) * TD - 1) step();
    bus.react = 1'b1; step(); bus.react = 1'b0;
    check_eq("last_tick_fault", 32'(bus.false_start), 1);
    check_eq("last_tick_led", 32'(bus.led), 0);

    // React on the timeout tick wins.
    bus.random = 4'd2; bus.start = 1'b1; step(); bus.start = 1'b0;
    wait_led(cnt);
    repeat (MAXRT * TD - 1) step();
    bus.react = 1'b1; step(); bus.react = 1'b0;
    check_eq("tout_tick_rt", 32'(bus.rt_ms), MAXRT - 1);
    check_eq("tout_tick_valid", 32'(bus.rt_valid), 1);
    check_eq("tout_tick_flag", 32'(bus.timeout), 0);

    // Reset during GO.
    bus.random = 4'd1; bus.start = 1'b1; step(); bus.start = 1'b0;
    wait_led(cnt);
    repeat (3) step();
    reset = 1'b0; step();
    check_eq("rst_go_led", 32'(bus.led), 0);
    check_eq("rst_go_busy", 32'(bus.busy), 0);
    check_eq("rst_go_best", 32'(bus.best_ms), 16383);
    reset = 1'b1; step();

    // Random button traffic, occasional reset.
    for (int i = 0; i < 5000; i++) begin
      bus.start  = ($urandom_range(0, 29) == 0);
      bus.react  = ($urandom_range(0, 39) == 0);
      bus.random = N'($urandom);
      reset      = ($urandom_range(0, 1499) != 0);
      step();
    end
    reset = 1'b1; bus.start = 1'b0; bus.react = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
